// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates the instruction-fetch port and the MEM-stage data port onto the
// single shared memory bus. One transaction at a time. The bus is driven from
// registers, the arbiter waits for bus_ack (or a timeout), and then returns the
// read data to the owning port with a one-cycle ready pulse.
//
// Transaction flow (IDLE -> REQ -> RESP -> IDLE):
//   IDLE : a pending request is granted. Its address, data, masks, direction
//          and owner are latched, and the timeout counter is loaded.
//   REQ  : bus_ce=1 and the bus fields are held. The state moves on when
//          bus_ack arrives or the counter runs out.
//   RESP : the owner's ready is high for exactly this cycle. bus_err is set
//          if the transaction timed out.
//
// Handshake: inst_req and data_ce are level requests. Each one is held until
// the matching ready pulse and dropped (or changed) for the next IDLE cycle.
// bus_ack is only accepted in REQ. bus_rdata is sampled on the accepting edge.
//
// Optional feature: define ARB_RR_EN to use round-robin arbitration on
// simultaneous requests. Without it, fixed priority is used and the data port
// wins.
//
// Parameters:
//   TIMEOUT    : number of REQ cycles without an ack before the transaction
//                is aborted (1..255)
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   inst_*     : fetch port (req/addr in, rdata/ready out)
//   data_*     : data port (ce/wr/addr/wdata/wmask/rmask in, rdata/ready out)
//   bus_*      : memory bus (ce/wr/rr/addr/wdata/wmask/rmask out,
//                rdata/ack in, err out)
//   stall_req  : pipeline stall; high while any port is waiting
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ready,
   input  logic        data_ce,
   input  logic        data_wr,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wmask,
   input  logic [3:0]  data_rmask,
   output logic [31:0] data_rdata,
   output logic        data_ready,
   output logic        bus_ce,
   output logic        bus_wr,
   output logic        bus_rr,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   output logic [3:0]  bus_rmask,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic        stall_req
);

   localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state;
   logic        owner_data;   // 1: data port owns the current transaction
   logic [7:0]  timer;        // remaining REQ cycles before timeout
   logic        grant_data;   // arbitration result for this IDLE cycle
   logic [31:0] capture;      // value returned to the owner when leaving REQ

`ifdef ARB_RR_EN
   // Round-robin pointer: 1 means the data port wins the next tie.
   // It starts pointing at data, so the first tie goes to the data port.
   logic prio_data;

   always_comb begin
      grant_data = data_ce;
      if (data_ce && inst_req) begin
         grant_data = prio_data;
      end
   end
`else
   // The MEM stage holds the older instruction, so the data port always wins.
   // This keeps the pipeline from deadlocking.
   always_comb begin
      grant_data = data_ce;
   end
`endif

   // Writes and timeouts both return zero. Only an acknowledged read returns
   // bus data.
   assign capture = (bus_ack && !bus_wr) ? bus_rdata : 32'h0;

   assign stall_req = (inst_req & ~inst_ready) | (data_ce & ~data_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner_data <= 1'b0;
         timer      <= 8'd0;
         bus_ce     <= 1'b0;
         bus_wr     <= 1'b0;
         bus_rr     <= 1'b0;
         bus_addr   <= 32'h0;
         bus_wdata  <= 32'h0;
         bus_wmask  <= 4'h0;
         bus_rmask  <= 4'h0;
         inst_rdata <= 32'h0;
         data_rdata <= 32'h0;
         inst_ready <= 1'b0;
         data_ready <= 1'b0;
         bus_err    <= 1'b0;
`ifdef ARB_RR_EN
         prio_data  <= 1'b1;
`endif
      end else begin
         // The ready and err outputs are single-cycle pulses. They are only
         // raised on the edge that enters RESP.
         inst_ready <= 1'b0;
         data_ready <= 1'b0;
         bus_err    <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (inst_req || data_ce) begin
                  state      <= ST_REQ;
                  owner_data <= grant_data;
                  timer      <= TIMEOUT_LOAD;
                  bus_ce     <= 1'b1;
`ifdef ARB_RR_EN
                  prio_data  <= ~grant_data;
`endif
                  if (grant_data) begin
                     bus_wr    <= data_wr;
                     bus_rr    <= ~data_wr;
                     bus_addr  <= data_addr;
                     bus_wdata <= data_wdata;
                     bus_wmask <= data_wmask;
                     bus_rmask <= data_rmask;
                  end else begin
                     bus_wr    <= 1'b0;
                     bus_rr    <= 1'b1;
                     bus_addr  <= inst_addr;
                     bus_wdata <= 32'h0;
                     bus_wmask <= 4'h0;
                     bus_rmask <= 4'hF;
                  end
               end
            end

            ST_REQ: begin
               // If the ack arrives in the last allowed cycle, the ack wins
               // over the timeout.
               if (bus_ack || timer == 8'd1) begin
                  state   <= ST_RESP;
                  bus_ce  <= 1'b0;
                  bus_wr  <= 1'b0;
                  bus_rr  <= 1'b0;
                  bus_err <= ~bus_ack;
                  if (owner_data) begin
                     data_rdata <= capture;
                     data_ready <= 1'b1;
                  end else begin
                     inst_rdata <= capture;
                     inst_ready <= 1'b1;
                  end
               end
               if (!bus_ack) begin
                  timer <= timer - 8'd1;
               end
            end

            ST_RESP: begin
               state <= ST_IDLE;
            end

            default: begin
               state  <= ST_IDLE;
               bus_ce <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. The bench acts as both requesters and the memory.
// The DUT is built with a short timeout.
module tb_mem_port_arbiter;

  localparam int T = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req = 0;
  logic [31:0] inst_addr = 0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_ce = 0;
  logic        data_wr = 0;
  logic [31:0] data_addr = 0;
  logic [31:0] data_wdata = 0;
  logic [3:0]  data_wmask = 0;
  logic [3:0]  data_rmask = 0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        bus_ce, bus_wr, bus_rr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask, bus_rmask;
  logic [31:0] bus_rdata = 0;
  logic        bus_ack = 0;
  logic        bus_err;
  logic        stall_req;

  mem_port_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_ce(data_ce), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wmask(data_wmask), .data_rmask(data_rmask), .data_rdata(data_rdata), .data_ready(data_ready),
    .bus_ce(bus_ce), .bus_wr(bus_wr), .bus_rr(bus_rr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_rmask(bus_rmask), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .stall_req(stall_req)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_inst_rd = 0;
  logic [31:0] exp_data_rd = 0;
  bit last_was_data = 1'b0;  // the model starts so that the first tie goes to data

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration rule
  function automatic logic pick_data(input logic ireq, input logic dce);
    if (ireq && dce) return RR ? ~last_was_data : 1'b1;
    return dce;
  endfunction

  // ---------------- driver: one whole transaction ----------------
  // Called at the falling edge of an idle cycle with the requests already
  // driven. It returns at the falling edge of the following idle cycle.
  task automatic run_txn(input int d, input logic [31:0] rd_val, input logic own_d,
                         input int exp_cycles, input logic exp_err, input logic [31:0] exp_rd);
    logic [73:0] exp_bus;
    logic [31:0] q_rd;
    int ce_cycles;
    int waited;
    bit got;
    ce_cycles = 0;
    waited = 0;
    got = 0;
    if (own_d) exp_bus = {data_wr, ~data_wr, data_addr, data_wdata, data_wmask, data_rmask};
    else       exp_bus = {1'b0, 1'b1, inst_addr, 32'h0, 4'h0, 4'hF};
    exp_q.push_back(exp_rd);
    while (!got && waited < 50) begin
      @(negedge clk);
      waited++;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (inst_ready || data_ready) got = 1;
      else if (bus_ce) begin
        ce_cycles++;
        check("bus_hold", {bus_wr, bus_rr, bus_addr, bus_wdata, bus_wmask, bus_rmask}, exp_bus);
        check("stall_busy", stall_req, inst_req | data_ce);
        if (ce_cycles == d + 1) begin
          bus_ack = 1'b1;
          bus_rdata = rd_val;
        end
      end
      // Ports that are not requesting may change freely. The bus must still
      // hold the latched fields.
      if (!inst_req) inst_addr = $urandom;
      if (!data_ce) begin
        data_wr = 1'($urandom_range(0, 1));
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wmask = 4'($urandom_range(0, 15));
        data_rmask = 4'($urandom_range(0, 15));
      end
    end
    q_rd = exp_q.pop_front();
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: no ready after %0d cycles, required within 50", waited);
      return;
    end
    if (own_d) exp_data_rd = q_rd;
    else       exp_inst_rd = q_rd;
    check("latency", waited, exp_cycles + 1);
    check("req_cycles", ce_cycles, exp_cycles);
    check("resp_bus_ce", bus_ce, 1'b0);
    check("ready_owner", {inst_ready, data_ready}, own_d ? 2'b01 : 2'b10);
    check("bus_err", bus_err, exp_err);
    check("inst_rdata", inst_rdata, exp_inst_rd);
    check("data_rdata", data_rdata, exp_data_rd);
    check("stall_resp", stall_req, own_d ? inst_req : data_ce);
    last_was_data = own_d;
    @(negedge clk);
    check("idle_quiet", {bus_ce, inst_ready, data_ready, bus_err}, 4'h0);
    if (own_d) data_ce = 1'b0;
    else       inst_req = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ireq;
    logic        dce;
    logic        dwr;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [3:0]  rmask;
    int          d;
    logic [31:0] rdv;
    logic        own_d;
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic ireq, input logic dce, input logic dwr,
                              input logic [31:0] iaddr, input logic [31:0] daddr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              input logic [3:0] rmask, input int d, input logic [31:0] rdv,
                              input logic own_d, input int cyc, input logic err,
                              input logic [31:0] rd);
    vec_t v;
    v.ireq = ireq; v.dce = dce; v.dwr = dwr; v.iaddr = iaddr; v.daddr = daddr;
    v.wdata = wdata; v.wmask = wmask; v.rmask = rmask; v.d = d; v.rdv = rdv;
    v.own_d = own_d; v.cyc = cyc; v.err = err; v.rd = rd;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs[NV];

  logic [159:0] zero_outs;

  initial begin
    int d;
    logic own, err;
    logic [31:0] rdv, rd;

    // tie sequence: data, then inst (data dropped, or lost the round-robin), then data
    vecs[0]  = mk(1, 1, 0, 32'h1000, 32'h2000, 32'h0, 4'h0, 4'hF, 0, 32'hA5A50001, 1, 1, 0, 32'hA5A50001);
    vecs[1]  = mk(1, RR, 1, 32'h1000, 32'h2008, 32'h12345678, 4'hC, 4'h0, 1, 32'h00001111, 0, 2, 0, 32'h00001111);
    vecs[2]  = mk(1, 1, 1, 32'h0040, 32'h2008, 32'h12345678, 4'hC, 4'h0, 0, 32'h00000099, 1, 1, 0, 32'h0);
    // single fetch, ack in the first REQ cycle
    vecs[3]  = mk(1, 0, 0, 32'h0040, 32'h0, 32'h0, 4'h0, 4'h0, 0, 32'h2402000A, 0, 1, 0, 32'h2402000A);
    // data write, ack in the third REQ cycle
    vecs[4]  = mk(0, 1, 1, 32'h0, 32'h100, 32'hDEADBEEF, 4'h3, 4'h0, 2, 32'h00005555, 1, 3, 0, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h0, 32'h200, 32'h0, 4'h0, 4'h6, 1, 32'h11223344, 1, 2, 0, 32'h11223344);
    // timeouts on both ports
    vecs[6]  = mk(1, 0, 0, 32'h0080, 32'h0, 32'h0, 4'h0, 4'h0, 9, 32'h77777777, 0, T, 1, 32'h0);
    vecs[7]  = mk(0, 1, 0, 32'h0, 32'h300, 32'h0, 4'h0, 4'hF, 9, 32'h66666666, 1, T, 1, 32'h0);
    // ack in the last cycle before the timeout wins
    vecs[8]  = mk(1, 0, 0, 32'h0084, 32'h0, 32'h0, 4'h0, 4'h0, T - 1, 32'hCAFEF00D, 0, T, 0, 32'hCAFEF00D);
    vecs[9]  = mk(1, 1, 0, 32'h0088, 32'h400, 32'h0, 4'h0, 4'hF, 0, 32'h0BADF00D, 1, 1, 0, 32'h0BADF00D);
    vecs[10] = mk(1, 0, 0, 32'h0088, 32'h0, 32'h0, 4'h0, 4'h0, 1, 32'h00000077, 0, 2, 0, 32'h00000077);

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    zero_outs = '0;
    check("reset_outs", {bus_ce, bus_wr, bus_rr, bus_addr, bus_wdata, bus_wmask, bus_rmask,
                         inst_rdata, data_rdata, inst_ready, data_ready, bus_err}, zero_outs);
    check("reset_stall", stall_req, 1'b0);

    // table
    for (int i = 0; i < NV; i++) begin
      inst_req = vecs[i].ireq;
      inst_addr = vecs[i].iaddr;
      data_ce = vecs[i].dce;
      data_wr = vecs[i].dwr;
      data_addr = vecs[i].daddr;
      data_wdata = vecs[i].wdata;
      data_wmask = vecs[i].wmask;
      data_rmask = vecs[i].rmask;
      run_txn(vecs[i].d, vecs[i].rdv, vecs[i].own_d, vecs[i].cyc, vecs[i].err, vecs[i].rd);
    end

    // randomized phase checked against the reference model
    for (int n = 0; n < 40; n++) begin
      if (!inst_req && $urandom_range(0, 1) == 1) begin
        inst_req = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_ce && ($urandom_range(0, 1) == 1 || !inst_req)) begin
        data_ce = 1'b1;
        data_wr = 1'($urandom_range(0, 1));
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wmask = 4'($urandom_range(0, 15));
        data_rmask = 4'($urandom_range(0, 15));
      end
      d = $urandom_range(0, 5);
      rdv = $urandom;
      own = pick_data(inst_req, data_ce);
      err = (d >= T);
      rd = (err || (own && data_wr)) ? 32'h0 : rdv;
      run_txn(d, rdv, own, err ? T : d + 1, err, rd);
    end

    // reset in the second REQ cycle, with a late ack one cycle after it
    data_ce = 1'b0;
    inst_req = 1'b1;
    inst_addr = 32'h300;
    @(negedge clk);
    check("rst_req1_ce", bus_ce, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    inst_req = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF0000;
    check("rst_mid_outs", {bus_ce, bus_wr, bus_rr, bus_addr, bus_wdata, bus_wmask, bus_rmask,
                           inst_rdata, data_rdata, inst_ready, data_ready, bus_err}, zero_outs);
    @(negedge clk);
    bus_ack = 1'b0;
    check("late_ack_ignored", {bus_ce, inst_ready, data_ready, bus_err}, 4'h0);
    last_was_data = 1'b0;
    exp_inst_rd = 32'h0;
    exp_data_rd = 32'h0;
    inst_req = 1'b1;
    inst_addr = 32'h304;
    run_txn(0, 32'h13579BDF, 1'b0, 1, 1'b0, 32'h13579BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
